// File: rtl/mem_bist_pkg.sv
// Shared definitions for the mem_bist march-test initiator.
//   state_t    : controller phases IDLE, WR0, RD0, WR1, RD1, FIN
//   phase_inv  : high for phases that use the inverted pattern
//   pattern    : P(a, seed) = a XOR seed (caller truncates to the word width)
//   RD_LAT_MAX : largest supported memory read latency
//   DRAIN_W    : width of the read-drain counter (counts 0..RD_LAT_MAX-1)
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_RD0  = 3'd2,
    ST_WR1  = 3'd3,
    ST_RD1  = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam int RD_LAT_MAX = 3;
  localparam int DRAIN_W    = 2;

  function automatic logic phase_inv(input state_t s);
    return (s == ST_WR1) || (s == ST_RD1);
  endfunction

  // Address is zero-extended to 32 bits; the caller truncates to WORD bits,
  // which gives the same result as truncating the address first.
  function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] seed);
    return a ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_rdpipe.sv
// Read-tracking pipe for mem_bist: delays {valid, address, expected word}
// by RD_LAT cycles so the compare lines up with the memory's read data.
//   clk, rst     : clock, asynchronous active-high reset (clears all valids)
//   flush        : drops every in-flight read on the next edge
//   issue_*      : read issued this cycle (valid, address, expected data)
//   cmp_*        : the read whose data is on mem_rdata this cycle
module mem_bist_rdpipe #(
  parameter int ADDR   = 4,
  parameter int WORD   = 4,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_vld,
  input  logic [ADDR-1:0] issue_addr,
  input  logic [WORD-1:0] issue_exp,
  output logic            cmp_vld,
  output logic [ADDR-1:0] cmp_addr,
  output logic [WORD-1:0] cmp_exp
);

  logic [RD_LAT-1:0]           vld_q;
  logic [RD_LAT-1:0][ADDR-1:0] addr_q;
  logic [RD_LAT-1:0][WORD-1:0] exp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      addr_q <= '0;
      exp_q  <= '0;
    end else begin
      vld_q[0]  <= issue_vld & ~flush;
      addr_q[0] <= issue_addr;
      exp_q[0]  <= issue_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1] & ~flush;
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign cmp_vld  = vld_q[RD_LAT-1];
  assign cmp_addr = addr_q[RD_LAT-1];
  assign cmp_exp  = exp_q[RD_LAT-1];

endmodule

// File: rtl/mem_bist.sv
// mem_bist: march self-test initiator for a single-port memory.
// Writes P(a) to every address, reads it back, writes ~P(a), reads it back.
// Optional feature macro MEM_BIST_ERRCNT_EN: adds err_count and disables
// the stop-on-first-mismatch abort.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request pulse, only looked at in IDLE
//   busy       : test running
//   done, fail : sticky results, cleared when a start is accepted
//   fail_addr  : address of the first mismatch (0 if none)
//   mem_addr, mem_wdata, mem_wr, mem_rdata : requester side of the memory
//   err_count  : (MEM_BIST_ERRCNT_EN only) number of mismatches
// Protocol: start is a one-cycle request with no ready; it is accepted only
// when the controller is IDLE, on which edge busy rises and done/fail clear.
// busy falls on the same edge that sets done; done stays high in FIN and
// IDLE until the next accepted start. Memory writes happen on every edge
// with mem_wr high; read data appears RD_LAT cycles after mem_addr is driven.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int              ADDR   = 4,
  parameter int              WORD   = 4,
  parameter logic [WORD-1:0] SEED   = WORD'(4'hA),
  parameter int              RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [ADDR-1:0] fail_addr,
  output logic [ADDR-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            mem_wr,
  input  logic [WORD-1:0] mem_rdata
`ifdef MEM_BIST_ERRCNT_EN
  ,
  output logic [ADDR+1:0] err_count
`endif
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_bist: RD_LAT out of range");
  end

  localparam logic [ADDR-1:0]    LAST_ADDR  = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

  function automatic logic [WORD-1:0] pat_word(input logic [ADDR-1:0] a, input logic inv);
    logic [WORD-1:0] p;
    p = WORD'(pattern(32'(a), 32'(SEED)));
    return inv ? ~p : p;
  endfunction

  state_t               state;
  logic                 rd_vld;
  logic [WORD-1:0]      rd_exp;
  logic [DRAIN_W-1:0]   drain;
  logic                 cmp_vld;
  logic [ADDR-1:0]      cmp_addr;
  logic [WORD-1:0]      cmp_exp;
  logic                 mismatch;
  logic                 abort;

  assign mismatch = cmp_vld && (mem_rdata != cmp_exp);
`ifdef MEM_BIST_ERRCNT_EN
  assign abort = 1'b0;
`else
  assign abort = mismatch;
`endif

  mem_bist_rdpipe #(
    .ADDR   (ADDR),
    .WORD   (WORD),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk        (clk),
    .rst        (rst),
    .flush      (abort),
    .issue_vld  (rd_vld),
    .issue_addr (mem_addr),
    .issue_exp  (rd_exp),
    .cmp_vld    (cmp_vld),
    .cmp_addr   (cmp_addr),
    .cmp_exp    (cmp_exp)
  );

  // mem_addr doubles as the phase address counter. Outputs are registered,
  // so each branch loads the values for the cycle that follows the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      rd_vld    <= 1'b0;
      rd_exp    <= '0;
      drain     <= '0;
`ifdef MEM_BIST_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WR0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            mem_wr    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= pat_word({ADDR{1'b0}}, 1'b0);
`ifdef MEM_BIST_ERRCNT_EN
            err_count <= '0;
`endif
          end
        end
        ST_WR0, ST_WR1: begin
          if (mem_addr == LAST_ADDR) begin
            state     <= (state == ST_WR0) ? ST_RD0 : ST_RD1;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= '0;
            rd_vld    <= 1'b1;
            rd_exp    <= pat_word({ADDR{1'b0}}, phase_inv(state));
          end else begin
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= pat_word(mem_addr + 1'b1, phase_inv(state));
          end
        end
        ST_RD0, ST_RD1: begin
          if (rd_vld) begin
            if (mem_addr == LAST_ADDR) begin
              rd_vld   <= 1'b0;
              mem_addr <= '0;
              drain    <= '0;
            end else begin
              mem_addr <= mem_addr + 1'b1;
              rd_exp   <= pat_word(mem_addr + 1'b1, phase_inv(state));
            end
          end else if (drain == DRAIN_LAST) begin
            // Last in-flight read is being compared this cycle.
            if (state == ST_RD0) begin
              state     <= ST_WR1;
              mem_wr    <= 1'b1;
              mem_wdata <= pat_word({ADDR{1'b0}}, 1'b1);
            end else begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            drain <= drain + 1'b1;
          end
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (mismatch) begin
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr;
        end
`ifdef MEM_BIST_ERRCNT_EN
        err_count <= err_count + 1'b1;
`endif
      end

      // Abort overrides whatever the phase logic chose above.
      if (abort) begin
        state     <= ST_FIN;
        busy      <= 1'b0;
        done      <= 1'b1;
        mem_wr    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        rd_vld    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
`timescale 1ns/1ps
module tb_mem_bist;

  localparam int ADDR = 4;
  localparam int WORD = 4;
  localparam int N    = 16;
  localparam logic [3:0] SEED = 4'hA;
`ifdef MEM_BIST_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif
  localparam int F_GOOD  = 0;
  localparam int F_STUCK = 1;
  localparam int F_ALIAS = 2;
  localparam int F_CELL  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start[2];
  logic       busy[2], done[2], fail[2], mem_wr[2];
  logic [3:0] fail_addr[2], mem_addr[2], mem_wdata[2], mem_rdata[2];
`ifdef MEM_BIST_ERRCNT_EN
  logic [5:0] err_count[2];
`endif

  mem_bist #(.ADDR(ADDR), .WORD(WORD), .SEED(SEED), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .fail(fail[0]), .fail_addr(fail_addr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wr(mem_wr[0]), .mem_rdata(mem_rdata[0])
`ifdef MEM_BIST_ERRCNT_EN
    , .err_count(err_count[0])
`endif
  );

  mem_bist #(.ADDR(ADDR), .WORD(WORD), .SEED(SEED), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .fail(fail[1]), .fail_addr(fail_addr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wr(mem_wr[1]), .mem_rdata(mem_rdata[1])
`ifdef MEM_BIST_ERRCNT_EN
    , .err_count(err_count[1])
`endif
  );

  // ---------------- faulty memory models ----------------
  int         fault[2];
  int         stuck_bit[2];
  int         bad_addr[2];
  logic [3:0] bad_mask[2];
  logic [3:0] marr[2][16];
  logic [3:0] rpipe[2][3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] eff_addr(input int f, input logic [3:0] a);
    return (f == F_ALIAS) ? (a & 4'h7) : a;
  endfunction

  function automatic logic [3:0] read_fault(input int f, input int sb, input int ba,
                                            input logic [3:0] bm, input logic [3:0] a,
                                            input logic [3:0] d);
    logic [3:0] one;
    one = 4'h1;
    if (f == F_STUCK) return d & ~(one << sb);
    if (f == F_CELL && int'(a) == ba) return d ^ bm;
    return d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wr[i]) marr[i][eff_addr(fault[i], mem_addr[i])] <= mem_wdata[i];
      rpipe[i][0] <= read_fault(fault[i], stuck_bit[i], bad_addr[i], bad_mask[i],
                                mem_addr[i], marr[i][eff_addr(fault[i], mem_addr[i])]);
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end
  assign mem_rdata[0] = rpipe[0][0];
  assign mem_rdata[1] = rpipe[1][2];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(input logic [3:0] a, input int ph);
    logic [3:0] p;
    p = a ^ SEED;
    return (ph != 0) ? ~p : p;
  endfunction

  // Model of one run: march over a plain array with the fault applied.
  // Cycle k=0 is the first busy cycle; phase ph starts at ph*(2N+L).
  int         m_len;
  int         m_first_k;
  logic [3:0] m_first_addr;
  int         exp_q[$];   // compare cycles of every mismatch

  task automatic build_model(input int i);
    logic [3:0] arr[16];
    logic [3:0] got;
    int L, base;
    L = lat_of(i);
    exp_q.delete();
    m_first_k = -1;
    m_first_addr = 4'h0;
    m_len = 4*N + 2*L;
    for (int ph = 0; ph < 2; ph++) begin
      base = ph * (2*N + L);
      for (int a = 0; a < N; a++) arr[eff_addr(fault[i], 4'(a))] = pat(4'(a), ph);
      for (int a = 0; a < N; a++) begin
        got = read_fault(fault[i], stuck_bit[i], bad_addr[i], bad_mask[i], 4'(a),
                         arr[eff_addr(fault[i], 4'(a))]);
        if (got != pat(4'(a), ph)) begin
          exp_q.push_back(base + N + a + L);
          if (m_first_k < 0) begin
            m_first_k = base + N + a + L;
            m_first_addr = 4'(a);
            if (!ERRCNT) begin
              m_len = m_first_k + 1;
              return;
            end
          end
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  bit         tracking = 1'b0;
  int         cur = 0;
  int         k = 0;
  int         cl;
  int         busy_seen;
  logic [3:0] w_at3;
  bit         in_w0, in_r0, in_w1, in_r1;
  int         n_err;

  always @(negedge clk) begin
    if (tracking) begin
      cl = lat_of(cur);
      n_err = 0;
      foreach (exp_q[j]) if (exp_q[j] < k) n_err++;
      if (busy[cur]) busy_seen++;
      if (k < m_len) begin
        in_w0 = (k < N);
        in_r0 = (k >= N) && (k < 2*N);
        in_w1 = (k >= 2*N + cl) && (k < 3*N + cl);
        in_r1 = (k >= 3*N + cl) && (k < 4*N + cl);
        check("busy", k, 32'(busy[cur]), 32'd1);
        check("done_low", k, 32'(done[cur]), 32'd0);
        check("mem_wr", k, 32'(mem_wr[cur]), 32'(in_w0 || in_w1));
        if (in_w0) begin
          check("wr0_addr", k, 32'(mem_addr[cur]), 32'(k));
          check("wr0_data", k, 32'(mem_wdata[cur]), 32'(pat(4'(k), 0)));
          if (mem_addr[cur] == 4'd3) w_at3 = mem_wdata[cur];
        end
        if (in_w1) begin
          check("wr1_addr", k, 32'(mem_addr[cur]), 32'(k - 2*N - cl));
          check("wr1_data", k, 32'(mem_wdata[cur]), 32'(pat(4'(k - 2*N - cl), 1)));
        end
        if (in_r0) check("rd0_addr", k, 32'(mem_addr[cur]), 32'(k - N));
        if (in_r1) check("rd1_addr", k, 32'(mem_addr[cur]), 32'(k - 3*N - cl));
      end else begin
        check("fin_busy", k, 32'(busy[cur]), 32'd0);
        check("fin_done", k, 32'(done[cur]), 32'd1);
        check("fin_mem_wr", k, 32'(mem_wr[cur]), 32'd0);
        check("fin_addr", k, 32'(mem_addr[cur]), 32'd0);
        check("fin_wdata", k, 32'(mem_wdata[cur]), 32'd0);
        tracking = 1'b0;
      end
      check("fail", k, 32'(fail[cur]), 32'(m_first_k >= 0 && k > m_first_k));
      check("fail_addr", k, 32'(fail_addr[cur]),
            (m_first_k >= 0 && k > m_first_k) ? 32'(m_first_addr) : 32'd0);
`ifdef MEM_BIST_ERRCNT_EN
      check("err_count", k, 32'(err_count[cur]), 32'(n_err));
`endif
      k++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input int i);
    @(posedge clk); #2;
    start[i] = 1'b1;
    @(posedge clk); #2;
    start[i] = 1'b0;
    cur = i;
    k = 0;
    busy_seen = 0;
    w_at3 = 4'h0;
    tracking = 1'b1;
  endtask

  task automatic run(input int i, input int f, input bit pulse_mid, input bit pulse_fin);
    int b;
    fault[i] = f;
    build_model(i);
    launch(i);
    b = 0;
    while (tracking && b < 300) begin
      @(posedge clk); #2;
      start[i] = (pulse_mid && (k == 5 || k == 40)) || (pulse_fin && k == m_len);
      b++;
    end
    start[i] = 1'b0;
    if (tracking) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: run on instance %0d did not finish within %0d cycles", i, b);
      tracking = 1'b0;
    end
    if (pulse_fin) begin
      repeat (3) begin
        @(negedge clk);
        check("post_fin_busy", -1, 32'(busy[i]), 32'd0);
        check("post_fin_done", -1, 32'(done[i]), 32'd1);
      end
    end
  endtask

  task automatic reset_mid(input int i);
    fault[i] = F_GOOD;
    build_model(i);
    launch(i);
    while (k < 10) begin
      @(posedge clk); #2;
    end
    check("pre_rst_mem_wr", k, 32'(mem_wr[i]), 32'd1);
    tracking = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mem_wr", k, 32'(mem_wr[i]), 32'd0);
    check("rst_busy", k, 32'(busy[i]), 32'd0);
    check("rst_done", k, 32'(done[i]), 32'd0);
    check("rst_fail", k, 32'(fail[i]), 32'd0);
    check("rst_addr", k, 32'(mem_addr[i]), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      fault[i] = F_GOOD;
      stuck_bit[i] = 2;
      bad_addr[i] = 15;
      bad_mask[i] = 4'h1;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 0, 32'(busy[i]), 32'd0);
      check("reset_done", 0, 32'(done[i]), 32'd0);
      check("reset_fail", 0, 32'(fail[i]), 32'd0);
      check("reset_fail_addr", 0, 32'(fail_addr[i]), 32'd0);
      check("reset_mem_wr", 0, 32'(mem_wr[i]), 32'd0);
      check("reset_addr", 0, 32'(mem_addr[i]), 32'd0);
      check("reset_wdata", 0, 32'(mem_wdata[i]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Good memory, latency 1: 66 busy cycles, address 3 written with 9.
    run(0, F_GOOD, 1'b0, 1'b0);
    check("lit_busy_66", -1, 32'(busy_seen), 32'd66);
    check("lit_wdata_at3", -1, 32'(w_at3), 32'h9);
    check("lit_good_fail", -1, 32'(fail[0]), 32'd0);

    // Data bit 2 stuck at 0: first bad address is 4.
    stuck_bit[0] = 2;
    run(0, F_STUCK, 1'b0, 1'b0);
    check("lit_stuck_fail", -1, 32'(fail[0]), 32'd1);
    check("lit_stuck_addr", -1, 32'(fail_addr[0]), 32'd4);
`ifdef MEM_BIST_ERRCNT_EN
    check("lit_stuck_errs", -1, 32'(err_count[0]), 32'd16);
    check("lit_stuck_busy", -1, 32'(busy_seen), 32'd66);
`else
    check("lit_stuck_busy", -1, 32'(busy_seen), 32'd22);
`endif

    // Starts during the run and during FIN are ignored; done/fail clear.
    idle_gap();
    run(0, F_GOOD, 1'b1, 1'b1);
    check("lit_busy_ignored", -1, 32'(busy_seen), 32'd66);

    // Memory ignores addr[3]: address 0 reads back P(8) = 2.
    run(0, F_ALIAS, 1'b0, 1'b0);
    check("lit_alias_fail", -1, 32'(fail[0]), 32'd1);
    check("lit_alias_addr", -1, 32'(fail_addr[0]), 32'd0);

    // Reset in the middle of WR0, then a clean full run.
    reset_mid(0);
    run(0, F_GOOD, 1'b0, 1'b0);
    check("lit_after_rst_busy", -1, 32'(busy_seen), 32'd66);

    // Latency 3.
    run(1, F_GOOD, 1'b0, 1'b0);
    check("lit_lat3_busy", -1, 32'(busy_seen), 32'd70);
    bad_addr[1] = 15;
    bad_mask[1] = 4'h1;
    run(1, F_CELL, 1'b0, 1'b0);
    check("lit_lat3_cell_addr", -1, 32'(fail_addr[1]), 32'd15);

    // Randomized runs against the model.
    for (int r = 0; r < 10; r++) begin
      int i;
      i = $urandom_range(0, 1);
      stuck_bit[i] = $urandom_range(0, 3);
      bad_addr[i] = $urandom_range(0, 15);
      bad_mask[i] = 4'($urandom_range(1, 15));
      idle_gap();
      run(i, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
Built-in self-test initiator for the single-port `mem` block (ADDR/WORD parameterised, ports clk/addr/data_in/wr/data_out).
- Drives the memory's write/read interface: it is the requester side of the `mem` protocol.
- Runs a four-phase pattern/inverse-pattern march over every address and reports pass/fail plus the first failing address.
- Sits between a control/status register block and the memory instance; muxed onto the memory port only while busy (mux is external).

Parameters:
ADDR, 4, memory address width; test covers all 2^ADDR locations
WORD, 4, memory data width
SEED, 4'hA (WORD bits), XOR seed for the test pattern
RD_LAT, 1, memory read latency in cycles (legal range 1..3)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to run the test; sampled only in IDLE
busy  output  1  high while the test runs
done  output  1  sticky; set when the test finishes, cleared by the next accepted start
fail  output  1  sticky; set on any mismatch, cleared by the next accepted start
fail_addr  output  ADDR  address of the first mismatch; 0 if none
mem_addr  output  ADDR  to mem addr
mem_wdata  output  WORD  to mem data_in
mem_wr  output  1  to mem wr; write on clock edge while high
mem_rdata  input  WORD  from mem data_out

Behaviour:
- Reset (async, immediate): all outputs 0, FSM in IDLE, read pipe cleared, mem_wr deasserts without waiting for clk.
- Pattern: P(a) = (a zero-extended or truncated to WORD bits) XOR SEED.
- FSM states:
  - IDLE: start=1 moves to WR0 and clears done/fail/fail_addr.
  - WR0: mem_wr=1, addr 0..2^ADDR-1, one per cycle, wdata=P(a).
  - RD0: mem_wr=0, issues addr 0..2^ADDR-1, one per cycle, then RD_LAT drain cycles.
  - WR1: same as WR0 with wdata=~P(a).
  - RD1: same as RD0, expecting ~P(a).
  - FIN: one cycle; sets done, returns to IDLE.
- Read pipe: expected data, address and valid bit delayed RD_LAT stages. When the delayed valid is high, compare mem_rdata against the delayed expected value.
- Throughput: one access per cycle.
- Busy duration: 4*2^ADDR + 2*RD_LAT cycles. busy rises on the edge that accepts start and falls on the edge that sets done.
- Wrap-around: the address counter reaching 2^ADDR-1 ends the phase and resets to 0 for the next phase. No address is skipped or repeated.
- On the first mismatch: fail=1 and fail_addr=delayed address. Later mismatches never overwrite fail_addr.
- Without MEM_BIST_ERRCNT_EN, a mismatch aborts the run: the FSM goes to FIN next cycle, in-flight reads are discarded and mem_wr drops to 0.
- start while busy is ignored; start asserted on the same cycle as FIN is ignored.
- mem_addr and mem_wdata are 0 in IDLE and FIN.

Optional Feature:
MEM_BIST_ERRCNT_EN
- Defined:
  - Adds output err_count [ADDR+1:0]. It counts every mismatch, is cleared on accepted start, and cannot overflow (max 2^(ADDR+1)).
  - The test always runs to completion; no abort on fail.
  - fail and fail_addr behave as above.
- Undefined: port absent; stop-on-first-fail behaviour.

Decomposition:
- Package mem_bist_pkg:
  - FSM state enum (IDLE, WR0, RD0, WR1, RD1, FIN)
  - phase-to-invert mapping
  - pattern function P(a, seed)
  - localparam for maximum RD_LAT
- Sub-module mem_bist_rdpipe: parameterised RD_LAT-deep shift register of {valid, addr, expected}. Async reset, flushed on abort.

Test Plan:
- Good mem, ADDR=4, WORD=4, SEED=A, RD_LAT=1; pulse start at cycle 0 -> busy high 66 cycles, mem_wr high cycles 1-16 with addr 3 -> wdata 9, done=1, fail=0, fail_addr=0.
- mem_rdata[2] stuck at 0 -> fail=1, fail_addr=4, run aborts in RD0. With MEM_BIST_ERRCNT_EN the run completes with err_count=16.
- Address aliasing (mem ignores addr[3]) -> first compare at addr 0 expects A, reads 2; fail=1, fail_addr=0.
- rst asserted at cycle 10 mid-WR0 -> mem_wr, busy, done, fail all 0 before the next edge. A fresh start then runs the full 66 cycles and passes.
- start pulsed at cycles 5 and 40 during a run -> ignored, total duration unchanged. A second run after done clears done/fail at accept.
- RD_LAT=3, good mem -> busy 70 cycles, pass. A deliberate single-cell corruption at addr 15 flags fail_addr=15, exercising the delayed-address path.
